// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// State encoding, frame sizing helper and the completed-frame counter width.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int BYTES_SENT_W = 16;

    // Frame length in bit periods: start + data + optional parity + stop.
    function automatic int frame_len(input int width, input int parity_en);
        return width + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the transmitter (master) and the FIFO (slave).
interface fifo_uart_tx_if #(
    parameter int f_WIDTH = 8
);
    logic               RD_EN;
    logic [f_WIDTH-1:0] f_out;
    logic               f_empty;

    modport master (
        output RD_EN,
        input  f_out,
        input  f_empty
    );

    modport slave (
        input  RD_EN,
        output f_out,
        output f_empty
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// A synchronous clear restarts the period whenever the transmitter changes state.
module uart_baud_tick #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             syn_rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign cnt  = cnt_reg;

    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO read port and serialises them as UART frames:
// start bit, data LSB first, optional parity bit, one stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int f_WIDTH      = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                    clk,
    input  logic                    syn_rst_n,
    input  logic                    tx_en,
    fifo_uart_tx_if.master          fifo,
    output logic                    tx_line,
    output logic                    tx_busy,
    output logic                    frame_done,
    output logic [BYTES_SENT_W-1:0] bytes_sent
);

    localparam int   CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int   IDX_W          = (f_WIDTH > 1) ? $clog2(f_WIDTH) : 1;
    localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

    tx_state_e               state_reg, state_next;
    logic [f_WIDTH-1:0]      shift_reg, shift_next;
    logic [IDX_W-1:0]        bit_idx_reg, bit_idx_next;
    logic                    parity_reg, parity_next;
    logic                    tx_line_reg, tx_line_next;
    logic                    rd_en_reg, rd_en_next;
    logic                    frame_done_reg, frame_done_next;
    logic [BYTES_SENT_W-1:0] bytes_sent_reg;

    logic             baud_clr;
    logic             baud_tick;
    logic [CNT_W-1:0] baud_cnt;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .syn_rst_n(syn_rst_n),
        .clr      (baud_clr),
        .cnt      (baud_cnt),
        .tick     (baud_tick)
    );

    // Every state change restarts the bit period from zero.
    assign baud_clr = (state_next != state_reg);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        parity_next  = parity_reg;
        case (state_reg)
            IDLE: begin
                if (tx_en && !fifo.f_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next   = fifo.f_out;
                parity_next  = (^fifo.f_out) ^ PARITY_ODD_BIT;
                bit_idx_next = '0;
                state_next   = START;
            end
            START: begin
                if (baud_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == IDX_W'(f_WIDTH - 1)) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        tx_line_next = 1'b1;
        case (state_next)
            START:   tx_line_next = 1'b0;
            DATA:    tx_line_next = shift_next[0];
            PARITY:  tx_line_next = parity_next;
            default: tx_line_next = 1'b1;
        endcase
        rd_en_next      = (state_next == POP);
        frame_done_next = (state_reg == STOP) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            parity_reg     <= 1'b0;
            tx_line_reg    <= 1'b1;
            rd_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            bytes_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_idx_reg    <= bit_idx_next;
            parity_reg     <= parity_next;
            tx_line_reg    <= tx_line_next;
            rd_en_reg      <= rd_en_next;
            frame_done_reg <= frame_done_next;
            if ((state_reg == STOP) && baud_tick) begin
                bytes_sent_reg <= bytes_sent_reg + 1'b1;
            end
        end
    end

    assign fifo.RD_EN = rd_en_reg;
    assign tx_line    = tx_line_reg;
    assign tx_busy    = (state_reg != IDLE);
    assign frame_done = frame_done_reg;
    assign bytes_sent = bytes_sent_reg;

endmodule
